seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
Controller that sequences the serial sequence-detector datapath and displays its results. It holds a programmable target pattern and gates serial bit acceptance through an IDLE/ARMED state machine. It tracks a sliding bit history, counts matches, and drives the 7-segment output with the hex match count. It sits between the top-level pin mapping (ui_in/uo_out) and the display.

Parameters:
PAT_LEN, 4, pattern length in bits; legal 2..8.
CNT_W, 4, match counter width; legal 1..4; the display shows the counter zero-extended to 4 bits.
OVERLAP, 1, 1 = history retained after a match (overlapping detection); 0 = history and fill cleared on a match.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  global enable; when low, cfg_load, bit_valid and clr are ignored
cfg_load  in  1  load pattern strobe
cfg_pattern  in  8  target pattern; bits [PAT_LEN-1:0] used, MSB first in time
bit_valid  in  1  serial bit strobe, one bit per high cycle
bit_in  in  1  serial data, sampled when bit_valid is high
clr  in  1  synchronous clear of match_cnt and ovf
armed  out  1  1 in ARMED state
det_pulse  out  1  one-cycle match pulse
match_cnt  out  CNT_W  match count
ovf  out  1  sticky counter wrap flag
seg  out  7  segments, seg[0]=a .. seg[6]=g, active high

Behaviour:
- Reset (rst_n low, effective immediately, no clock needed):
  - state IDLE, pattern 0, history 0, fill 0.
  - armed 0, det_pulse 0, match_cnt 0, ovf 0, seg 7'h3F.
- All registers update on the rising clk edge. seg is combinational decode of registered match_cnt.
- IDLE:
  - bit_valid ignored.
  - ena & cfg_load -> latch cfg_pattern[PAT_LEN-1:0], clear history and fill, go to ARMED.
- ARMED:
  - ena & cfg_load -> reload pattern, clear history and fill, stay ARMED. match_cnt and ovf are not affected.
  - ena & bit_valid & !cfg_load -> hist_n = {hist[PAT_LEN-2:0], bit_in}; fill_n = min(fill+1, PAT_LEN).
  - Match condition: fill_n == PAT_LEN and hist_n == pattern.
  - On a match at edge k:
    - det_pulse = 1 for exactly the cycle after edge k.
    - match_cnt increments at the same edge.
    - If OVERLAP=0, history and fill clear to 0.
- No path back to IDLE except reset.
- Counter wrap: when match_cnt is all-ones and a match occurs, match_cnt wraps to 0 and ovf is set (sticky).
- clr (with ena): match_cnt = 0, ovf = 0.
  - clr beats a same-cycle increment: count ends at 0, but det_pulse is still asserted.
- cfg_load and bit_valid in the same cycle: cfg_load wins; the bit is dropped.
- ena low: every state and register holds, and det_pulse goes to 0.
- Latency: final pattern bit sampled at edge k -> det_pulse, match_cnt and seg all update after edge k (1 cycle).
- Back-to-back bit_valid every cycle must be supported, including consecutive matches on consecutive cycles.
- seg hex decode of {0-extend match_cnt}:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71

Test Plan:
(All with PAT_LEN=4, CNT_W=4.)
1. Reset: rst_n=0, then release -> armed=0, match_cnt=0, ovf=0, det_pulse=0, seg=7'h3F. bit_valid with bit_in 1,0,1,1 while IDLE -> no pulse, count stays 0.
2. Basic match: load 8'h0B, feed 1,0,1,1 on consecutive cycles -> det_pulse high exactly one cycle after the 4th bit edge, match_cnt=1, seg=7'h06. Same stream with ena=0 -> no change.
3. Overlap: pattern 1011, stream 1,0,1,1,0,1,1 -> OVERLAP=1: 2 pulses (after bits 4 and 7), count 2, seg=7'h5B. OVERLAP=0: 1 pulse, count 1.
4. Wrap and clear: 16 matches -> match_cnt=0, ovf=1, seg=7'h3F. Then clr -> ovf=0. clr coincident with a match -> det_pulse=1, count=0.
5. Reload priority: cfg_load with 8'h06 in the same cycle as bit_valid=1 -> bit dropped, fill=0. Then stream 0,1,1,0 -> match after the 4th bit; the earlier partial history does not cause a match.
6. Async reset mid-stream: after 3 of 4 pattern bits, pull rst_n low between edges -> armed, match_cnt and det_pulse go to 0 before the next edge. After release, stream 1,0,1,1 -> no match until reloaded.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Serial sequence-detector controller: programmable pattern, IDLE/ARMED gating,
// sliding bit history, match counter with sticky wrap flag and hex 7-segment readout.
module seq_det_ctrl #(
    parameter int unsigned PAT_LEN = 4,
    parameter int unsigned CNT_W   = 4,
    parameter bit          OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cfg_load,
    input  logic [7:0]       cfg_pattern,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clr,
    output logic             armed,
    output logic             det_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             ovf,
    output logic [6:0]       seg
);
    localparam int unsigned      FillW    = $clog2(PAT_LEN + 1);
    localparam logic [FillW-1:0] FillFull = FillW'(PAT_LEN);

    typedef enum logic [0:0] {StIdle, StArmed} state_e;

    state_e             state_q;
    logic [PAT_LEN-1:0] pattern_q;
    logic [PAT_LEN-1:0] hist_q;
    logic [FillW-1:0]   fill_q;

    logic [PAT_LEN-1:0] hist_n;
    logic [FillW-1:0]   fill_n;
    logic               shift_en;
    logic               match;
    logic [3:0]         cnt_hex;

    // cfg_load takes priority over a same-cycle bit, so the bit is simply not shifted.
    always_comb begin
        hist_n   = {hist_q[PAT_LEN-2:0], bit_in};
        fill_n   = (fill_q == FillFull) ? fill_q : fill_q + FillW'(1);
        shift_en = ena && (state_q == StArmed) && bit_valid && !cfg_load;
        match    = shift_en && (fill_n == FillFull) && (hist_n == pattern_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pattern_q <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            armed     <= 1'b0;
            det_pulse <= 1'b0;
            match_cnt <= '0;
            ovf       <= 1'b0;
        end else begin
            det_pulse <= 1'b0;
            if (ena) begin
                if (cfg_load) begin
                    pattern_q <= cfg_pattern[PAT_LEN-1:0];
                    hist_q    <= '0;
                    fill_q    <= '0;
                    state_q   <= StArmed;
                    armed     <= 1'b1;
                end else if (shift_en) begin
                    if (match && !OVERLAP) begin
                        hist_q <= '0;
                        fill_q <= '0;
                    end else begin
                        hist_q <= hist_n;
                        fill_q <= fill_n;
                    end
                end

                if (match) begin
                    det_pulse <= 1'b1;
                    match_cnt <= match_cnt + CNT_W'(1);
                    if (&match_cnt) begin
                        ovf <= 1'b1;
                    end
                end

                // Clear overrides a coincident increment; the pulse above still fires.
                if (clr) begin
                    match_cnt <= '0;
                    ovf       <= 1'b0;
                end
            end
        end
    end

    assign cnt_hex = 4'(match_cnt);

    always_comb begin
        seg = 7'h00;
        unique case (cnt_hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: overlapping and non-overlapping instances driven in lockstep,
// checked against a queue-based model, a vector table and directed corner sequences.
module tb_seq_det_ctrl;
    localparam int PL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, cfg_load, bit_valid, bit_in, clr;
    logic [7:0] cfg_pattern;

    logic       armed0, det0, ovf0, armed1, det1, ovf1;
    logic [3:0] cnt0, cnt1;
    logic [6:0] seg0, seg1;

    seq_det_ctrl #(.PAT_LEN(PL), .CNT_W(4), .OVERLAP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .bit_valid(bit_valid), .bit_in(bit_in), .clr(clr), .armed(armed0), .det_pulse(det0),
        .match_cnt(cnt0), .ovf(ovf0), .seg(seg0)
    );

    seq_det_ctrl #(.PAT_LEN(PL), .CNT_W(4), .OVERLAP(1'b0)) dut_no (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .bit_valid(bit_valid), .bit_in(bit_in), .clr(clr), .armed(armed1), .det_pulse(det1),
        .match_cnt(cnt1), .ovf(ovf1), .seg(seg1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_p0, n_p1;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: bits accepted since the last load (or last match when non-overlapping).
    bit         m_armed;
    logic [7:0] m_pat;
    bit         m_q0[$];
    bit         m_q1[$];
    int         m_cnt0, m_cnt1;
    bit         m_ovf0, m_ovf1, m_p0, m_p1;

    typedef struct {
        bit         e, l;
        logic [7:0] p;
        bit         v, b, c;
        bit         exp_pulse;
        int         exp_cnt;
        logic [6:0] exp_seg;
    } vec_t;
    vec_t vecs[$];

    function automatic bit hits(input bit q[$], input logic [7:0] p);
        if (q.size() < PL) return 1'b0;
        for (int i = 0; i < PL; i++) begin
            if (q[q.size() - 1 - i] != p[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_pat = '0; m_q0.delete(); m_q1.delete();
        m_cnt0 = 0; m_cnt1 = 0; m_ovf0 = 0; m_ovf1 = 0; m_p0 = 0; m_p1 = 0;
    endtask

    task automatic model_edge();
        m_p0 = 0;
        m_p1 = 0;
        if (ena) begin
            if (cfg_load) begin
                m_pat = cfg_pattern & 8'h0F;
                m_armed = 1;
                m_q0.delete();
                m_q1.delete();
            end else if (m_armed && bit_valid) begin
                m_q0.push_back(bit_in);
                m_q1.push_back(bit_in);
                if (m_q0.size() > 8) void'(m_q0.pop_front());
                if (m_q1.size() > 8) void'(m_q1.pop_front());
                if (hits(m_q0, m_pat)) begin
                    m_p0 = 1;
                    m_cnt0 = (m_cnt0 + 1) % 16;
                    if (m_cnt0 == 0) m_ovf0 = 1;
                end
                if (hits(m_q1, m_pat)) begin
                    m_p1 = 1;
                    m_cnt1 = (m_cnt1 + 1) % 16;
                    if (m_cnt1 == 0) m_ovf1 = 1;
                    m_q1.delete();
                end
            end
            if (clr) begin
                m_cnt0 = 0; m_ovf0 = 0; m_cnt1 = 0; m_ovf1 = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("armed", int'(armed0), int'(m_armed));
        chk("det_pulse", int'(det0), int'(m_p0));
        chk("match_cnt", int'(cnt0), m_cnt0);
        chk("ovf", int'(ovf0), int'(m_ovf0));
        chk("seg", int'(seg0), int'(seg_tab[m_cnt0]));
        chk("armed_no", int'(armed1), int'(m_armed));
        chk("det_pulse_no", int'(det1), int'(m_p1));
        chk("match_cnt_no", int'(cnt1), m_cnt1);
        chk("ovf_no", int'(ovf1), int'(m_ovf1));
        chk("seg_no", int'(seg1), int'(seg_tab[m_cnt1]));
    endtask

    task automatic step(input bit e, input bit l, input logic [7:0] p, input bit v,
                        input bit b, input bit c);
        ena = e; cfg_load = l; cfg_pattern = p; bit_valid = v; bit_in = b; clr = c;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        if (det0) n_p0++;
        if (det1) n_p1++;
    endtask

    task automatic feed(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1, 0, 8'h00, 1, bits[i], 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 0; cfg_load = 0; cfg_pattern = '0; bit_valid = 0; bit_in = 0; clr = 0;
        model_reset();

        // 1. Reset, then bits while IDLE are ignored
        #2;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        n_p0 = 0; n_p1 = 0;
        feed(8'b1011, 4);
        chk("idle_pulses", n_p0, 0);
        chk("idle_cnt", int'(cnt0), 0);

        // 2. Basic match, then ena low holds everything and drops the pulse
        vecs.push_back('{1, 1, 8'h0B, 0, 0, 0, 0, 0, 7'h3F});
        vecs.push_back('{1, 0, 8'h00, 1, 1, 0, 0, 0, 7'h3F});
        vecs.push_back('{1, 0, 8'h00, 1, 0, 0, 0, 0, 7'h3F});
        vecs.push_back('{1, 0, 8'h00, 1, 1, 0, 0, 0, 7'h3F});
        vecs.push_back('{1, 0, 8'h00, 1, 1, 0, 1, 1, 7'h06});
        vecs.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 1, 7'h06});
        vecs.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 1, 7'h06});
        vecs.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 1, 7'h06});
        vecs.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 1, 7'h06});
        vecs.push_back('{0, 1, 8'h06, 1, 1, 1, 0, 1, 7'h06});
        foreach (vecs[i]) begin
            step(vecs[i].e, vecs[i].l, vecs[i].p, vecs[i].v, vecs[i].b, vecs[i].c);
            chk($sformatf("vec%0d_pulse", i), int'(det0), int'(vecs[i].exp_pulse));
            chk($sformatf("vec%0d_cnt", i), int'(cnt0), vecs[i].exp_cnt);
            chk($sformatf("vec%0d_seg", i), int'(seg0), int'(vecs[i].exp_seg));
        end

        // 3. Overlap vs non-overlap on 1,0,1,1,0,1,1
        step(1, 0, 8'h00, 0, 0, 1);
        step(1, 1, 8'h0B, 0, 0, 0);
        n_p0 = 0; n_p1 = 0;
        feed(8'b1011011, 7);
        chk("ovl_pulses", n_p0, 2);
        chk("ovl_cnt", int'(cnt0), 2);
        chk("ovl_seg", int'(seg0), 7'h5B);
        chk("novl_pulses", n_p1, 1);
        chk("novl_cnt", int'(cnt1), 1);

        // 4. Wrap to zero with sticky ovf, clear, clear coincident with a match
        step(1, 0, 8'h00, 0, 0, 1);
        step(1, 1, 8'h0F, 0, 0, 0);
        for (int i = 0; i < 19; i++) step(1, 0, 8'h00, 1, 1, 0);
        chk("wrap_cnt", int'(cnt0), 0);
        chk("wrap_ovf", int'(ovf0), 1);
        chk("wrap_seg", int'(seg0), 7'h3F);
        step(1, 0, 8'h00, 0, 0, 1);
        chk("clr_ovf", int'(ovf0), 0);
        step(1, 0, 8'h00, 1, 1, 1);
        chk("clr_match_pulse", int'(det0), 1);
        chk("clr_match_cnt", int'(cnt0), 0);

        // 5. Reload beats a same-cycle bit and clears partial history
        step(1, 1, 8'h0B, 0, 0, 0);
        feed(8'b011, 3);
        step(1, 1, 8'h06, 1, 0, 0);
        n_p0 = 0;
        feed(8'b011, 3);
        chk("reload_early", n_p0, 0);
        feed(8'b0, 1);
        chk("reload_pulse", int'(det0), 1);
        chk("reload_total", n_p0, 1);

        // 6. Asynchronous reset between edges, mid-stream
        step(1, 1, 8'h0B, 0, 0, 0);
        feed(8'b1011, 4);
        feed(8'b101, 3);
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("arst_armed", int'(armed0), 0);
        chk("arst_cnt", int'(cnt0), 0);
        chk("arst_pulse", int'(det0), 0);
        check_all();
        #3;
        rst_n = 1'b1;
        n_p0 = 0;
        feed(8'b1011, 4);
        chk("post_rst_pulses", n_p0, 0);
        chk("post_rst_armed", int'(armed0), 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, 8'($urandom),
                 $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 29) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
